if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Fetch stage of the 5-stage MIPS pipeline: owns the PC and the IF/ID pipeline register, and drives the instruction-memory request.
//  Feeds the decode stage with instr_decode, pc_decode and valid_decode.
//  Consumes the decode-stage redirect (pcsrc_decode/pc_branch, jump_decode/pc_jump) and the hazard-unit stall.
//  A 4-state FSM handles variable-latency imem, redirect during an outstanding fetch, and stall during a fetch return.
// PARAMETERS
//  WIDTH     32           datapath/PC width (`WIDTH)
//  RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst           in   1      asynchronous, active-low reset
//  stall_decode  in   1      hazard unit: hold IF/ID, no new fetch accepted
//  pcsrc_decode  in   1      branch taken in ID
//  jump_decode   in   1      jump in ID
//  pc_branch     in   WIDTH  branch target
//  pc_jump       in   WIDTH  jump target
//  imem_req      out  1      fetch request; address held stable while high
//  imem_addr     out  WIDTH  fetch address (= PC register)
//  imem_ready    in   1      imem_rdata valid for imem_addr this cycle (0+ wait states)
//  imem_rdata    in   WIDTH  fetched instruction
//  instr_decode  out  WIDTH  IF/ID instruction
//  pc_decode     out  WIDTH  IF/ID PC+4 of that instruction
//  valid_decode  out  1      IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst=0, async)
//   - pc=RESET_PC, state=IDLE, buf=0.
//   - instr_decode=0, pc_decode=0, valid_decode=0, imem_req=0.
//  Definitions
//   - redir  = (pcsrc_decode|jump_decode) & ~stall_decode.
//   - target = jump_decode ? pc_jump : pc_branch (jump wins if both).
//   - bubble: instr=0 (nop), pc_decode=0, valid=0.
//   - hold: IF/ID keeps its value.
//   - PC+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC -> 0). Targets are used as given; no alignment fix-up.
//  imem_req = 1 in FETCH and DRAIN, 0 in IDLE and HOLD. imem_addr = pc always.
//  IDLE: first cycle after reset release. Req=0, IF/ID bubble, -> FETCH.
//  FETCH
//   - redir & ready:     discard rdata, pc<=target, IF/ID bubble, stay.
//   - redir & ~ready:    rpc<=target, IF/ID bubble, -> DRAIN (address must stay stable).
//   - stall & ready:     buf<=rdata, IF/ID hold, pc unchanged, -> HOLD.
//   - stall & ~ready:    IF/ID hold, stay.
//   - ~stall & ready:    IF/ID<={rdata, pc+4, 1}, pc<=pc+4, stay.
//   - ~stall & ~ready:   IF/ID bubble, stay.
//  DRAIN
//   - Req stays high on the old pc until ready.
//   - On ready: discard rdata, pc<=rpc, -> FETCH.
//   - IF/ID: hold if stall, else bubble.
//   - Redirect inputs are ignored in this state.
//  HOLD
//   - Stays until ~stall_decode.
//   - Then, if redir: drop buf, pc<=target, IF/ID bubble, -> FETCH.
//   - Else: IF/ID<={buf, pc+4, 1}, pc<=pc+4, -> FETCH.
//  Latency
//   - Zero-wait imem gives 1 instruction/cycle; the instruction fetched in cycle N appears on IF/ID in cycle N+1.
//   - A taken redirect costs exactly 1 bubble with zero-wait imem.
//  Reset mid-operation: immediate return to reset values. Any outstanding imem response is not tracked; the memory must also be reset.
// TESTING
//  1. Reset release, ready=1, imem returns addr-derived words
//     -> IF/ID shows (I@0, pc 4), (I@4, pc 8), ... every cycle after IDLE; imem_req=0 in IDLE.
//  2. pcsrc_decode=1, pc_branch=0x40 at pc=0x10, ready=1
//     -> next IF/ID is a bubble; imem_addr=0x40; following IF/ID = (I@0x40, pc 0x44).
//  3. ready=0 for 3 cycles, jump_decode=1 (pc_jump=0x100) in the first of them
//     -> imem_addr stays at the old pc until ready, that data is discarded, then addr=0x100; only bubbles on IF/ID meanwhile.
//  4. stall_decode=1 for 2 cycles while ready=1
//     -> IF/ID held, req drops in HOLD, buffered instruction appears after stall release, no instruction lost or duplicated.
//  5. HOLD, then stall release with pcsrc_decode=1 -> buffered instruction dropped, IF/ID bubble, fetch from pc_branch.
//  6. pc=0xFFFF_FFFC fetch -> pc_decode=0, next imem_addr=0. Assert rst=0 mid-DRAIN -> all outputs 0 immediately; restart from RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: owns the PC and the IF/ID register,
// and issues instruction-memory requests. IF/ID updates one cycle after imem
// returns data. Stalls hold IF/ID; a stall that arrives together with returning
// data parks that word in a buffer. A redirect during an outstanding fetch
// waits until the old fetch completes.
// Ports: clk/rst (async active-low); stall_decode, pcsrc_decode/pc_branch and
// jump_decode/pc_jump from decode; imem_req/imem_addr/imem_ready/imem_rdata to
// the instruction memory; instr_decode/pc_decode/valid_decode form IF/ID.
module if_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_decode,
  input  logic             pcsrc_decode,
  input  logic             jump_decode,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic [WIDTH-1:0] pc_jump,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_decode,
  output logic [WIDTH-1:0] pc_decode,
  output logic             valid_decode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rpc;        // redirect target waiting for the old fetch to finish
  logic [WIDTH-1:0] instr_buf;  // word returned while decode was stalled

  logic             redir;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_plus4;

  // A stalled decode stage cannot act on its own branch or jump.
  assign redir    = (pcsrc_decode | jump_decode) & ~stall_decode;
  assign target   = jump_decode ? pc_jump : pc_branch;
  assign pc_plus4 = pc + WIDTH'(4);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      rpc          <= '0;
      instr_buf    <= '0;
      imem_req     <= 1'b0;
      instr_decode <= '0;
      pc_decode    <= '0;
      valid_decode <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          instr_decode <= '0;
          pc_decode    <= '0;
          valid_decode <= 1'b0;
          imem_req     <= 1'b1;
          state        <= S_FETCH;
        end

        S_FETCH: begin
          if (redir) begin
            instr_decode <= '0;
            pc_decode    <= '0;
            valid_decode <= 1'b0;
            if (imem_ready) begin
              pc <= target;
            end else begin
              // Memory still owns the current address; keep it until it answers.
              rpc   <= target;
              state <= S_DRAIN;
            end
          end else if (stall_decode) begin
            if (imem_ready) begin
              instr_buf <= imem_rdata;
              imem_req  <= 1'b0;
              state     <= S_HOLD;
            end
          end else if (imem_ready) begin
            instr_decode <= imem_rdata;
            pc_decode    <= pc_plus4;
            valid_decode <= 1'b1;
            pc           <= pc_plus4;
          end else begin
            instr_decode <= '0;
            pc_decode    <= '0;
            valid_decode <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (!stall_decode) begin
            instr_decode <= '0;
            pc_decode    <= '0;
            valid_decode <= 1'b0;
          end
          if (imem_ready) begin
            pc    <= rpc;
            state <= S_FETCH;
          end
        end

        S_HOLD: begin
          if (!stall_decode) begin
            imem_req <= 1'b1;
            state    <= S_FETCH;
            if (redir) begin
              instr_decode <= '0;
              pc_decode    <= '0;
              valid_decode <= 1'b0;
              pc           <= target;
            end else begin
              instr_decode <= instr_buf;
              pc_decode    <= pc_plus4;
              valid_decode <= 1'b1;
              pc           <= pc_plus4;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a transaction-level model
// of the fetch stream (started / parked word / locked redirect).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_decode = 1'b0;
  logic        pcsrc_decode = 1'b0;
  logic        jump_decode  = 1'b0;
  logic [31:0] pc_branch    = '0;
  logic [31:0] pc_jump      = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready   = 1'b0;
  logic [31:0] imem_rdata   = '0;
  logic [31:0] instr_decode;
  logic [31:0] pc_decode;
  logic        valid_decode;

  if_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_decode (stall_decode),
    .pcsrc_decode (pcsrc_decode),
    .jump_decode  (jump_decode),
    .pc_branch    (pc_branch),
    .pc_jump      (pc_jump),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_decode (instr_decode),
    .pc_decode    (pc_decode),
    .valid_decode (valid_decode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
  endfunction

  // Reference model of the fetch stream.
  logic        m_started;    // first post-reset cycle already spent
  logic        m_parked;     // a fetched word is waiting for decode to unstall
  logic [31:0] m_park_word;
  logic        m_locked;     // redirect pending behind an unanswered fetch
  logic [31:0] m_lock_tgt;
  logic [31:0] m_pc;
  logic [31:0] m_instr, m_pcd;
  logic        m_vld;

  task automatic model_reset();
    m_started = 0; m_parked = 0; m_park_word = '0; m_locked = 0; m_lock_tgt = '0;
    m_pc = 32'h0; m_instr = '0; m_pcd = '0; m_vld = 0;
  endtask

  task automatic bubble();
    m_instr = '0; m_pcd = '0; m_vld = 0;
  endtask

  task automatic deliver(input logic [31:0] w);
    m_instr = w; m_pcd = m_pc + 32'd4; m_vld = 1; m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step(input logic st, input logic pcs, input logic jmp,
                            input logic [31:0] pb, input logic [31:0] pj, input logic rdy);
    logic        redir;
    logic [31:0] tgt;
    redir = (pcs | jmp) & ~st;
    tgt   = jmp ? pj : pb;
    if (!m_started) begin
      bubble();
      m_started = 1;
    end else if (m_parked) begin
      if (!st) begin
        m_parked = 0;
        if (redir) begin bubble(); m_pc = tgt; end
        else deliver(m_park_word);
      end
    end else if (m_locked) begin
      if (!st) bubble();
      if (rdy) begin m_pc = m_lock_tgt; m_locked = 0; end
    end else if (redir) begin
      bubble();
      if (rdy) m_pc = tgt;
      else begin m_locked = 1; m_lock_tgt = tgt; end
    end else if (st) begin
      if (rdy) begin m_parked = 1; m_park_word = mem_word(m_pc); end
    end else if (rdy) begin
      deliver(mem_word(m_pc));
    end else begin
      bubble();
    end
  endtask

  task automatic compare_outputs();
    check("imem_req",     {31'b0, imem_req},     {31'b0, m_started & ~m_parked});
    check("imem_addr",    imem_addr,             m_pc);
    check("instr_decode", instr_decode,          m_instr);
    check("pc_decode",    pc_decode,             m_pcd);
    check("valid_decode", {31'b0, valid_decode}, {31'b0, m_vld});
  endtask

  // Called at a falling edge: check current outputs, drive one cycle of inputs,
  // advance the model, and return at the next falling edge.
  task automatic cycle(input logic st, input logic pcs, input logic jmp,
                       input logic [31:0] pb, input logic [31:0] pj, input logic rdy);
    compare_outputs();
    stall_decode = st; pcsrc_decode = pcs; jump_decode = jmp;
    pc_branch = pb; pc_jump = pj; imem_ready = rdy;
    imem_rdata = rdy ? mem_word(m_pc) : $urandom;
    model_step(st, pcs, jmp, pb, pj, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_req",   {31'b0, imem_req},     32'h0);
    check("rst_addr",  imem_addr,             32'h0);
    check("rst_instr", instr_decode,          32'h0);
    check("rst_pcd",   pc_decode,             32'h0);
    check("rst_vld",   {31'b0, valid_decode}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    @(negedge clk);
    do_reset();

    // Zero-wait streaming from reset.
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1);

    // Branch at pc=0x10.
    do_reset();
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 32'h40, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Jump while memory is waiting.
    cycle(0, 0, 1, 0, 32'h100, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Stall for 2 cycles with ready data, then release.
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);

    // Stall, then release together with a taken branch.
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 32'h300, 0, 1);
    cycle(0, 1, 0, 32'h80, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 0, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Reset while draining an outstanding fetch.
    cycle(0, 0, 1, 0, 32'h200, 0);
    cycle(0, 0, 0, 0, 0, 0);
    compare_outputs();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        st, pcs, jmp, rdy;
      logic [31:0] pb, pj;
      st  = ($urandom % 4) == 0;
      pcs = ($urandom % 6) == 0;
      jmp = ($urandom % 8) == 0;
      rdy = ($urandom % 3) != 0;
      pb  = $urandom & 32'hFFFF_FFFC;
      pj  = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 16) == 0) pb = 32'hFFFF_FFFC;
      if (($urandom % 16) == 0) pj = 32'hFFFF_FFF8;
      if (i % 700 == 350) do_reset();
      cycle(st, pcs, jmp, pb, pj, rdy);
    end
    compare_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
